// File: rtl/wdt_rst_req_pkg.sv
// Shared definitions for the watchdog, the reset generator and the reset-cause status register.
package wdt_rst_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } wdt_state_t;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PCNT_W = 16;
    localparam int unsigned FCNT_W = 8;

    localparam logic [FCNT_W-1:0] FCNT_MAX = 8'd255;

    // Increment that sticks at FCNT_MAX so the count never wraps back to a small value.
    function automatic logic [FCNT_W-1:0] fcnt_sat_inc(input logic [FCNT_W-1:0] v);
        return (v == FCNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wdt_rst_req.sv
// Watchdog timer: counts idle cycles since the last kick and issues a fixed-length
// reset request pulse on timeout, with warning, sticky cause flag and fire counter.
module wdt_rst_req
    import wdt_rst_req_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 1000*1000*100,
    parameter int unsigned WARN_MARGIN = 1000*1000*10,
    parameter int unsigned PULSE_LEN   = 16
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              enable,
    input  logic              kick,
    input  logic              clear_cause,
    output logic              rst_req,
    output logic              warn,
    output logic              fired,
    output logic [FCNT_W-1:0] fire_cnt,
    output logic [CNT_W-1:0]  cnt_out
);

    localparam logic [CNT_W-1:0]  TERM    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  WARN_AT = CNT_W'(TIMEOUT - WARN_MARGIN);
    localparam logic [PCNT_W-1:0] PEND    = PCNT_W'(PULSE_LEN - 1);

    wdt_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [PCNT_W-1:0] pcnt, pcnt_n;
    logic              rst_req_n, warn_n, fired_n;
    logic [FCNT_W-1:0] fire_cnt_n;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            pcnt     <= '0;
            rst_req  <= 1'b0;
            warn     <= 1'b0;
            fired    <= 1'b0;
            fire_cnt <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pcnt     <= pcnt_n;
            rst_req  <= rst_req_n;
            warn     <= warn_n;
            fired    <= fired_n;
            fire_cnt <= fire_cnt_n;
        end
    end

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pcnt_n     = pcnt;
        rst_req_n  = rst_req;
        warn_n     = warn;
        fired_n    = fired;
        fire_cnt_n = fire_cnt;

        // Clear is applied first so a coincident fire increments from zero and wins.
        if (clear_cause) begin
            fired_n    = 1'b0;
            fire_cnt_n = '0;
        end

        case (state)
            IDLE: begin
                cnt_n     = '0;
                warn_n    = 1'b0;
                rst_req_n = 1'b0;
                if (enable) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    warn_n  = 1'b0;
                end else if (kick) begin
                    cnt_n  = '0;
                    warn_n = 1'b0;
                end else if (cnt == TERM) begin
                    state_n    = FIRE;
                    rst_req_n  = 1'b1;
                    pcnt_n     = '0;
                    cnt_n      = '0;
                    warn_n     = 1'b0;
                    fired_n    = 1'b1;
                    fire_cnt_n = fcnt_sat_inc(fire_cnt_n);
                end else begin
                    cnt_n  = cnt_inc;
                    warn_n = (cnt_inc >= WARN_AT);
                end
            end

            FIRE: begin
                if (pcnt == PEND) begin
                    rst_req_n = 1'b0;
                    pcnt_n    = '0;
                    cnt_n     = '0;
                    state_n   = enable ? RUN : IDLE;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end

            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                pcnt_n    = '0;
                rst_req_n = 1'b0;
                warn_n    = 1'b0;
            end
        endcase
    end

    assign cnt_out = cnt;

endmodule

// File: tb/tb_wdt_rst_req.sv
// Directed self-checking bench for wdt_rst_req with TIMEOUT=20, WARN_MARGIN=5, PULSE_LEN=4.
module tb_wdt_rst_req;

    logic        clk;
    logic        rst_in;
    logic        enable;
    logic        kick;
    logic        clear_cause;
    logic        rst_req;
    logic        warn;
    logic        fired;
    logic [7:0]  fire_cnt;
    logic [31:0] cnt_out;

    int unsigned total;
    int unsigned bad;

    wdt_rst_req #(
        .TIMEOUT     (20),
        .WARN_MARGIN (5),
        .PULSE_LEN   (4)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .enable      (enable),
        .kick        (kick),
        .clear_cause (clear_cause),
        .rst_req     (rst_req),
        .warn        (warn),
        .fired       (fired),
        .fire_cnt    (fire_cnt),
        .cnt_out     (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_in = 1'b1; enable = 1'b0; kick = 1'b0; clear_cause = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rst_req", rst_req, 0);
        chk("rst_warn", warn, 0);
        chk("rst_fired", fired, 0);
        chk("rst_fire_cnt", fire_cnt, 0);
        chk("rst_cnt", cnt_out, 0);
        rst_in = 1'b0;
        @(negedge clk);

        // 1: regular kicking
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 500; i++) begin
            kick = (i % 10 == 0);
            @(negedge clk);
            chk("t1_rst_req", rst_req, 0);
            chk("t1_warn", warn, 0);
            chk("t1_cnt_le10", (cnt_out <= 10), 1);
        end
        kick = 1'b0;
        chk("t1_fired", fired, 0);
        chk("t1_fire_cnt", fire_cnt, 0);

        // 2: single kick then silence, two full timeouts
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        chk("t2_cnt_e", cnt_out, 0);
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            chk("t2_rst_req", rst_req, ((k >= 20 && k <= 23) || (k >= 44 && k <= 47)));
            chk("t2_warn", warn, ((k >= 15 && k < 20) || (k >= 39 && k < 44)));
            chk("t2_cnt", cnt_out, (k < 20) ? k : (k < 24) ? 0 : (k < 44) ? k - 24 : (k < 48) ? 0 : k - 48);
            chk("t2_fired", fired, (k >= 20));
            chk("t2_fire_cnt", fire_cnt, (k >= 44) ? 2 : (k >= 20) ? 1 : 0);
        end
        clear_cause = 1'b1;
        @(negedge clk);
        clear_cause = 1'b0;
        chk("t2_clr_fired", fired, 0);
        chk("t2_clr_fire_cnt", fire_cnt, 0);

        // 3: kick on terminal edge
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        repeat (19) @(negedge clk);
        chk("t3_cnt19", cnt_out, 19);
        chk("t3_warn_pre", warn, 1);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        chk("t3_rst_req", rst_req, 0);
        chk("t3_cnt", cnt_out, 0);
        chk("t3_warn", warn, 0);
        @(negedge clk);
        chk("t3_rst_req_after", rst_req, 0);
        chk("t3_cnt_after", cnt_out, 1);
        chk("t3_fired", fired, 0);

        // 4A: drop enable while warn is high
        repeat (15) @(negedge clk);
        chk("t4a_cnt16", cnt_out, 16);
        chk("t4a_warn_pre", warn, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("t4a_warn", warn, 0);
        chk("t4a_cnt", cnt_out, 0);
        kick = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("t4a_idle_cnt", cnt_out, 0);
            chk("t4a_idle_rst_req", rst_req, 0);
        end
        kick = 1'b0;
        chk("t4a_fired", fired, 0);

        // 4B: drop enable on the second pulse cycle
        enable = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("t4b_rst_req_run", rst_req, (k == 20));
        end
        chk("t4b_fire_cnt", fire_cnt, 1);
        enable = 1'b0;
        for (int k = 21; k <= 24; k++) begin
            @(negedge clk);
            chk("t4b_rst_req_pulse", rst_req, (k <= 23));
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t4b_idle_rst_req", rst_req, 0);
            chk("t4b_idle_cnt", cnt_out, 0);
        end
        chk("t4b_fired", fired, 1);
        chk("t4b_fire_cnt_end", fire_cnt, 1);

        // 5: async reset mid-pulse
        enable = 1'b1;
        @(negedge clk);
        repeat (21) @(negedge clk);
        chk("t5_rst_req_pre", rst_req, 1);
        chk("t5_fire_cnt_pre", fire_cnt, 2);
        #2 rst_in = 1'b1;
        #1;
        chk("t5_rst_req", rst_req, 0);
        chk("t5_fired", fired, 0);
        chk("t5_fire_cnt", fire_cnt, 0);
        chk("t5_cnt", cnt_out, 0);
        #1 rst_in = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("t5_fresh_rst_req", rst_req, (k == 20));
            chk("t5_fresh_warn", warn, (k >= 15 && k < 20));
        end
        chk("t5_fire_cnt_new", fire_cnt, 1);

        // 6: saturation over 300 further timeouts, then clear and clear-vs-fire priority
        repeat (300 * 24) @(negedge clk);
        chk("t6_sat", fire_cnt, 255);
        chk("t6_sat_fired", fired, 1);
        chk("t6_phase_rst_req", rst_req, 1);
        repeat (48) @(negedge clk);
        chk("t6_sat_hold", fire_cnt, 255);
        clear_cause = 1'b1;
        @(negedge clk);
        clear_cause = 1'b0;
        chk("t6_clr_fired", fired, 0);
        chk("t6_clr_fire_cnt", fire_cnt, 0);
        repeat (22) @(negedge clk);
        chk("t6_pre_entry_rst_req", rst_req, 0);
        chk("t6_pre_entry_warn", warn, 1);
        clear_cause = 1'b1;
        @(negedge clk);
        clear_cause = 1'b0;
        chk("t6_prio_rst_req", rst_req, 1);
        chk("t6_prio_fired", fired, 1);
        chk("t6_prio_fire_cnt", fire_cnt, 1);
        @(negedge clk);
        chk("t6_prio_hold", fire_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wdt_rst_req.md
Name: wdt_rst_req

Overview:
- Watchdog timer. Counts idle cycles since the last software `kick`.
- On timeout, emits a fixed-length active-high reset request. That request drives the `rst_in` input of the power-on reset generator, which converts it into the system-wide `rst`/`rstn` hold-off.
- Also provides an early-warning flag, a sticky fired flag and a saturating fire counter for post-reset cause inspection.
- Sits in the always-on clock domain next to the reset generator.

Parameters:
- TIMEOUT, 1000*1000*100, idle cycles from last kick to reset request (≥ 2, ≤ 2^32-1).
- WARN_MARGIN, 1000*1000*10, `warn` asserts this many cycles before timeout (1 ≤ WARN_MARGIN < TIMEOUT).
- PULSE_LEN, 16, `rst_req` high time in cycles (1..65535).

Ports:
- clk, input, 1: single clock.
- rst_in, input, 1: asynchronous active-high reset. It is external and is never driven by this block's own `rst_req`.
- enable, input, 1: level; arms the watchdog.
- kick, input, 1: level, sampled each clk; restarts the timeout.
- clear_cause, input, 1: one-cycle strobe; clears `fired` and `fire_cnt`.
- rst_req, output, 1: reset request pulse to the reset generator.
- warn, output, 1: timeout imminent.
- fired, output, 1: sticky; a timeout has occurred.
- fire_cnt, output, 8: saturating count of timeouts.
- cnt_out, output, 32: current idle count, for debug readback.

Behaviour:
- Reset (rst_in=1, async, immediate, no clock needed):
  - state=IDLE; cnt=0, pcnt=0.
  - rst_req=0, warn=0, fired=0, fire_cnt=0.
- All outputs are registered. cnt is 32 bits; pcnt is 16 bits.
- States: IDLE, RUN, FIRE.
- IDLE:
  - cnt held 0; kick ignored.
  - enable=1 sampled → RUN on the next edge, cnt=0.
- RUN:
  - enable=0 → IDLE, cnt<=0, warn<=0. Enable has priority over everything else.
  - Else kick=1 → cnt<=0, warn<=0.
  - Else if cnt==TIMEOUT-1 → FIRE: rst_req<=1, pcnt<=0, cnt<=0, warn<=0, fired<=1, fire_cnt<=min(fire_cnt+1,255).
  - Else cnt<=cnt+1; warn<=1 when the new cnt ≥ TIMEOUT-WARN_MARGIN.
- Timing consequences:
  - With a kick sampled at edge E and none afterwards, warn rises at edge E+(TIMEOUT-WARN_MARGIN).
  - rst_req rises at edge E+TIMEOUT.
  - The same holds when counting starts from RUN entry at edge E.
- Kick and terminal count on the same edge: kick wins, no fire.
- FIRE:
  - rst_req stays 1 while pcnt increments.
  - At pcnt==PULSE_LEN-1: rst_req<=0, pcnt<=0, next state = RUN (cnt=0) if enable=1, else IDLE.
  - rst_req is therefore high for exactly PULSE_LEN cycles.
  - kick and enable are ignored while in FIRE; the pulse always completes.
- clear_cause:
  - Sets fired<=0 and fire_cnt<=0 in any state.
  - If it coincides with the FIRE-entry edge, the fire wins: fired=1, fire_cnt=1.
- fire_cnt saturates at 255 and never wraps.
- cnt_out = cnt.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, FIRE}, 2-bit encoding;
  - CNT_W=32, PCNT_W=16, FCNT_W=8;
  - FCNT_MAX=255.
- The package is shared with the reset generator and a future reset-cause status register.
- No sub-module; counters and FSM stay in one module (~150 lines).

Test Plan (TIMEOUT=20, WARN_MARGIN=5, PULSE_LEN=4):
1. Regular kicking:
   - Stimulus: enable=1; kick for 1 cycle every 10 cycles, for 500 cycles.
   - Required: rst_req and warn never assert; fired=0, fire_cnt=0; cnt_out never exceeds 10.
2. Single kick then silence:
   - Stimulus: one kick at edge E, no further kicks.
   - Required: warn=1 from edge E+15; rst_req=1 for edges E+20..E+23 (4 cycles), with warn=0 from E+20; fired=1, fire_cnt=1.
   - Required after the pulse: re-enters RUN; second rst_req rises at edge E+44.
3. Kick on terminal edge:
   - Stimulus: kick coincident with the edge where cnt_out=19.
   - Required: no rst_req; cnt_out=0; warn=0.
4. Enable dropped mid-run and mid-pulse:
   - Stimulus A: drop enable while warn=1. Required: warn=0 and cnt_out=0 after one edge; no fire.
   - Stimulus B: drop enable on the 2nd rst_req cycle. Required: rst_req still totals 4 cycles, then state IDLE with no further fires.
5. Async reset mid-pulse:
   - Stimulus: assert rst_in between clk edges during FIRE.
   - Required: rst_req, fired and fire_cnt go to 0 before the next edge.
   - Required after release with enable=1: fresh timeout of 20 edges.
6. Saturation and clear priority:
   - Stimulus: enable with no kicks for 300 timeouts.
   - Required: fire_cnt=255 and holds.
   - Stimulus: clear_cause. Required: fired=0, fire_cnt=0.
   - Stimulus: clear_cause on the FIRE-entry edge. Required: fired=1, fire_cnt=1.
